// File: rtl/ram_bus_arbiter_pkg.sv
// riscv_bus_pkg: shared constants for the data-RAM bus arbiter.
// State codes double as the owner status codes.
package riscv_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // Hold counter must represent 0..max_hold.
  function automatic int cnt_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: two requester ports plus the RAM port.
// slave = arbiter view, master = requesters/RAM view.
interface ram_bus_arbiter_if #(
  parameter int ADDR_WIDTH = riscv_bus_pkg::ADDR_W_DEF,
  parameter int DATA_WIDTH = riscv_bus_pkg::DATA_W_DEF
) ();

  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic [DATA_WIDTH-1:0] ram_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_ack, m1_rdata,
    output ram_addr, ram_we, ram_wd,
    input  ram_rd
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_ack, m1_rdata,
    input  ram_addr, ram_we, ram_wd,
    output ram_rd
  );

endinterface

// File: rtl/ram_bus_arbiter_hold.sv
// arb_hold_counter: transfers done by the current owner.
// Ports: clk, rst (async low), clr, inc -> limit (cnt==MAX), near (cnt==MAX-1).
module arb_hold_counter
  import riscv_bus_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit,
  output logic near
);

  localparam int CW = cnt_w(MAX_HOLD);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_HOLD);
  localparam logic [CW-1:0] PRE_V = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX_V) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign limit = (cnt == MAX_V);
  assign near  = (cnt == PRE_V);

endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin, bounded-hold sharing of the data RAM.
// Ports: clk, rst (async low), bus (slave modport), owner (00/01/10).
module ram_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int MAX_HOLD   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ram_bus_arbiter_if.slave        bus,
  output logic [1:0]              owner
);

  logic [1:0] st;
  logic [1:0] st_nxt;
  logic       last_q;
  logic       gnt0;
  logic       gnt1;
  logic       xfer0;
  logic       xfer1;
  logic       xfer;
  logic       limit;
  logic       near;
  logic       hit;
  logic       clr;
  logic       ack0_q;
  logic       ack1_q;
  logic       rd0_q;
  logic       rd1_q;

  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wd_mux;
  logic                  we_mux;

  assign gnt0  = (st == ST_OWN0);
  assign gnt1  = (st == ST_OWN1);
  assign xfer0 = gnt0 & bus.m0_req;
  assign xfer1 = gnt1 & bus.m1_req;
  assign xfer  = xfer0 | xfer1;
  // This transfer brings the count to MAX_HOLD (or it already sits there).
  assign hit   = xfer & (limit | near);

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (xfer),
    .limit (limit),
    .near  (near)
  );

  always_comb begin
    st_nxt = st;
    clr    = 1'b0;
    unique case (1'b1)
      gnt0: begin
        if (!bus.m0_req) begin
          st_nxt = bus.m1_req ? ST_OWN1 : ST_IDLE;
          clr    = 1'b1;
        end else if (hit && bus.m1_req) begin
          st_nxt = ST_OWN1;
          clr    = 1'b1;
        end
      end
      gnt1: begin
        if (!bus.m1_req) begin
          st_nxt = bus.m0_req ? ST_OWN0 : ST_IDLE;
          clr    = 1'b1;
        end else if (hit && bus.m0_req) begin
          st_nxt = ST_OWN0;
          clr    = 1'b1;
        end
      end
      default: begin
        clr = 1'b1;
        // On a tie, serve whoever was not served last.
        if (bus.m0_req && (!bus.m1_req || last_q)) begin
          st_nxt = ST_OWN0;
        end else if (bus.m1_req) begin
          st_nxt = ST_OWN1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= ST_IDLE;
      last_q <= 1'b1;
    end else begin
      st <= st_nxt;
      if (xfer0) begin
        last_q <= 1'b0;
      end else if (xfer1) begin
        last_q <= 1'b1;
      end
    end
  end

  always_comb begin
    addr_mux = '0;
    we_mux   = 1'b0;
    wd_mux   = '0;
    unique case (1'b1)
      gnt0: begin
        addr_mux = bus.m0_addr;
        we_mux   = bus.m0_we & bus.m0_req;
        wd_mux   = bus.m0_wdata;
      end
      gnt1: begin
        addr_mux = bus.m1_addr;
        we_mux   = bus.m1_we & bus.m1_req;
        wd_mux   = bus.m1_wdata;
      end
      default: begin
      end
    endcase
  end

  assign bus.ram_addr = addr_mux;
  assign bus.ram_we   = we_mux;
  assign bus.ram_wd   = wd_mux;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd0_q    <= 1'b0;
      rd1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= xfer0;
      ack1_q <= xfer1;
      rd0_q  <= xfer0 & ~bus.m0_we;
      rd1_q  <= xfer1 & ~bus.m1_we;
      if (rd0_q) rdata0_q <= bus.ram_rd;
      if (rd1_q) rdata1_q <= bus.ram_rd;
    end
  end

  // RAM data arrives in the ack cycle; pass it through, then hold it.
  assign bus.m0_rdata = rd0_q ? bus.ram_rd : rdata0_q;
  assign bus.m1_rdata = rd1_q ? bus.ram_rd : rdata1_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign owner        = st;

endmodule
